cube_frame_tx: RTL

//  Host-side frame transmitter for the CUBE0414 LED-cube byte protocol. On start it reads one frame

---
 rtl/cube_frame_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/cube_frame_tx.sv
// cube_frame_tx: streams one CUBE0414 frame (address map + pixel data) from memory to a byte serializer
module cube_frame_tx #(
  parameter logic [7:0] CMD_ADDR_WR = 8'hcc,
  parameter logic [7:0] CMD_DATA_WR = 8'hda,
  parameter bit         SEND_ADDR   = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  output logic        rd_en_out,
  output logic        rd_map_out,
  output logic [10:0] rd_addr_out,
  input  logic [7:0]  rd_data_in,
  output logic        byte_valid_out,
  input  logic        byte_ready_in,
  output logic [7:0]  byte_data_out,
  output logic        dc_out,
  output logic        busy_out,
  output logic        frame_done_out
);
  typedef enum logic [2:0] {IDLE, ACMD, AMAP, DCMD, PIX} state_t;
  state_t state, state_nx;
  logic [5:0] idx, idx_nx, pixel, pixel_nx;
  logic [2:0] layer, layer_nx;
  logic [1:0] colour, colour_nx;
  logic       pend, hs, last_map, last_pix;
  assign hs       = byte_valid_out & byte_ready_in;
  assign last_map = idx == 6'd63;
  assign last_pix = layer == 3'd0 && pixel == 6'd63 && colour == 2'd2;
  assign busy_out = state != IDLE;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_nx;
  // Counters track the byte currently being presented; the read for the next byte goes out in the handshake cycle
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    pixel_nx  = pixel;
    layer_nx  = layer;
    colour_nx = colour;
    case (state)
      IDLE: if (start_in) state_nx = SEND_ADDR ? ACMD : DCMD;
      ACMD: if (hs) begin
        state_nx = AMAP;
        idx_nx   = 6'd0;
      end
      AMAP: if (hs) begin
        if (last_map) state_nx = DCMD;
        else idx_nx = idx + 6'd1;
      end
      DCMD: if (hs) begin
        state_nx  = PIX;
        layer_nx  = 3'd7;
        pixel_nx  = 6'd0;
        colour_nx = 2'd0;
      end
      PIX: if (hs) begin
        if (last_pix) state_nx = IDLE;
        else begin
          colour_nx = colour == 2'd2 ? 2'd0 : colour + 2'd1;
          pixel_nx  = colour == 2'd2 ? pixel + 6'd1 : pixel;
          layer_nx  = colour == 2'd2 && pixel == 6'd63 ? layer - 3'd1 : layer;
        end
      end
      default: state_nx = IDLE;
    endcase
    rd_en_out   = hs && (state_nx == AMAP || state_nx == PIX);
    rd_map_out  = rd_en_out && state_nx == AMAP;
    rd_addr_out = !rd_en_out ? 11'd0 : rd_map_out ? {5'b0, idx_nx} : {layer_nx, pixel_nx, colour_nx};
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      pend           <= 1'b0;
      frame_done_out <= 1'b0;
      byte_valid_out <= 1'b0;
      byte_data_out  <= 8'd0;
      dc_out         <= 1'b0;
      idx            <= 6'd0;
      pixel          <= 6'd0;
      layer          <= 3'd0;
      colour         <= 2'd0;
    end else begin
      pend           <= rd_en_out;
      frame_done_out <= state == PIX && hs && last_pix;
      idx            <= idx_nx;
      pixel          <= pixel_nx;
      layer          <= layer_nx;
      colour         <= colour_nx;
      if (state == IDLE && start_in) begin
        byte_valid_out <= 1'b1;
        byte_data_out  <= SEND_ADDR ? CMD_ADDR_WR : CMD_DATA_WR;
        dc_out         <= 1'b0;
      end else if (state == AMAP && hs && last_map) begin
        byte_data_out <= CMD_DATA_WR;
        dc_out        <= 1'b0;
      end else if (pend) begin
        byte_valid_out <= 1'b1;
        byte_data_out  <= rd_data_in;
        dc_out         <= 1'b1;
      end else if (hs) byte_valid_out <= 1'b0;
    end
endmodule
